// File: rtl/fp_normalize_pack.sv
// Normalises a raw adder result one bit per clock and packs it into an
// IEEE-754 single-precision word with {overflow, underflow, zero} flags.
module fp_normalize_pack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic [EXP_W-1:0]         in_exponent,
  input  logic [MAN_W+1:0]         in_fract,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_fp,
  output logic [2:0]               out_flags
);

  localparam int FP_W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [2:0] FLAG_OVF = 3'b100;
  localparam logic [2:0] FLAG_UNF = 3'b010;
  localparam logic [2:0] FLAG_ZERO = 3'b001;

  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

  state_t            state_reg, state_next;
  logic              sign_reg, sign_next;
  // One extra exponent bit so the carry increment cannot wrap.
  logic [EXP_W:0]    exp_reg, exp_next;
  logic [MAN_W+1:0]  fract_reg, fract_next;
  logic [FP_W-1:0]   fp_reg, fp_next;
  logic [2:0]        flags_reg, flags_next;

  logic [EXP_W:0]    exp_inc;
  logic [EXP_W:0]    exp_dec;
  logic [MAN_W+1:0]  fract_shl;
  logic [FP_W-1:0]   fp_ovf;

  assign exp_inc   = exp_reg + EXP_ONE;
  assign exp_dec   = exp_reg - EXP_ONE;
  assign fract_shl = fract_reg << 1;
  assign fp_ovf    = {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_fp    = fp_reg;
  assign out_flags = flags_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      sign_reg  <= 1'b0;
      exp_reg   <= '0;
      fract_reg <= '0;
      fp_reg    <= '0;
      flags_reg <= '0;
    end else begin
      state_reg <= state_next;
      sign_reg  <= sign_next;
      exp_reg   <= exp_next;
      fract_reg <= fract_next;
      fp_reg    <= fp_next;
      flags_reg <= flags_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sign_next  = sign_reg;
    exp_next   = exp_reg;
    fract_next = fract_reg;
    fp_next    = fp_reg;
    flags_next = flags_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sign_next  = in_sign;
          exp_next   = {1'b0, in_exponent};
          fract_next = in_fract;
          state_next = CHECK;
        end
      end

      CHECK: begin
        state_next = DONE;
        if (fract_reg == '0) begin
          fp_next    = '0;
          flags_next = FLAG_ZERO;
        end else if (exp_reg == EXP_MAX) begin
          fp_next    = fp_ovf;
          flags_next = FLAG_OVF;
        end else if (exp_reg == '0) begin
          fp_next    = '0;
          flags_next = FLAG_UNF;
        end else if (fract_reg[MAN_W+1]) begin
          // Carry out: shift right once, dropping the LSB.
          fract_next = fract_reg >> 1;
          exp_next   = exp_inc;
          if (exp_inc == EXP_MAX) begin
            fp_next    = fp_ovf;
            flags_next = FLAG_OVF;
          end else begin
            fp_next    = {sign_reg, exp_inc[EXP_W-1:0], fract_reg[MAN_W:1]};
            flags_next = 3'b000;
          end
        end else if (fract_reg[MAN_W]) begin
          fp_next    = {sign_reg, exp_reg[EXP_W-1:0], fract_reg[MAN_W-1:0]};
          flags_next = 3'b000;
        end else begin
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        if (exp_reg == EXP_ONE) begin
          fp_next    = '0;
          flags_next = FLAG_UNF;
          state_next = DONE;
        end else begin
          exp_next   = exp_dec;
          fract_next = fract_shl;
          if (fract_shl[MAN_W]) begin
            fp_next    = {sign_reg, exp_dec[EXP_W-1:0], fract_shl[MAN_W-1:0]};
            flags_next = 3'b000;
            state_next = DONE;
          end
        end
      end

      DONE: begin
        if (out_ready) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Directed bench for fp_normalize_pack: expected results go into a scoreboard
// queue when an operand is driven and are popped when out_valid appears.
module tb_fp_normalize_pack;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exponent;
  logic [24:0] in_fract;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_fp;
  logic [2:0]  out_flags;

  fp_normalize_pack #(.EXP_W(8), .MAN_W(23)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exponent (in_exponent),
    .in_fract    (in_fract),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_fp      (out_fp),
    .out_flags   (out_flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] fp;
    logic [2:0]  flags;
    int          lat;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   total_checks = 0;
  int   passed_checks = 0;

  task automatic check(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    total_checks++;
    assert (obs === expv) passed_checks++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Drive one operand, wait (bounded) for the result, hold out_ready low
  // for hold cycles, then release and confirm the return to IDLE.
  task automatic do_op(input logic s, input logic [7:0] e, input logic [24:0] f,
                       input logic [31:0] efp, input logic [2:0] efl,
                       input int lat, input int hold, input string tag);
    exp_t item;
    exp_t got;
    int   n;
    item.fp = efp; item.flags = efl; item.lat = lat; item.tag = tag;
    exp_q.push_back(item);
    check({31'd0, in_ready}, 32'd1, {tag, ".ready_idle"});
    in_sign = s; in_exponent = e; in_fract = f; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    check({31'd0, in_ready}, 32'd0, {tag, ".ready_busy"});
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    if (exp_q.size() == 0) begin
      check(32'hDEAD, 32'h0, {tag, ".queue_empty"});
    end else begin
      got = exp_q.pop_front();
      check(n, got.lat, {got.tag, ".latency"});
      check(out_fp, got.fp, {got.tag, ".fp"});
      check({29'd0, out_flags}, {29'd0, got.flags}, {got.tag, ".flags"});
      for (int i = 0; i < hold; i++) begin
        @(posedge clock); #1;
        check({31'd0, out_valid}, 32'd1, {got.tag, ".hold_valid"});
        check(out_fp, got.fp, {got.tag, ".hold_fp"});
        check({29'd0, out_flags}, {29'd0, got.flags}, {got.tag, ".hold_flags"});
        check({31'd0, in_ready}, 32'd0, {got.tag, ".hold_ready"});
      end
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check({31'd0, out_valid}, 32'd0, {tag, ".valid_drop"});
    check({31'd0, in_ready}, 32'd1, {tag, ".ready_back"});
    $display("op %s sign=%0b exp=%0d fract=%h -> fp=%h flags=%b", tag, s, e, f, efp, efl);
    @(posedge clock); #1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0;
    in_exponent = 8'd0; in_fract = 25'd0; out_ready = 1'b0;
    #2;
    // Operand offered while reset is held must be ignored.
    in_valid = 1'b1; in_exponent = 8'd127; in_fract = 25'h0C00000;
    repeat (3) @(posedge clock);
    #1;
    check({31'd0, out_valid}, 32'd0, "reset.valid");
    check(out_fp, 32'd0, "reset.fp");
    check({29'd0, out_flags}, 32'd0, "reset.flags");
    check({31'd0, in_ready}, 32'd1, "reset.ready");
    in_valid = 1'b0;
    #3 reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check({31'd0, in_ready}, 32'd1, "post_reset.ready");

    do_op(1'b0, 8'd127, 25'h0C00000, 32'h3FC00000, 3'b000, 1, 0, "normal");
    do_op(1'b0, 8'd127, 25'h1800000, 32'h40400000, 3'b000, 1, 0, "carry");
    do_op(1'b0, 8'd130, 25'h0100000, 32'h3F800000, 3'b000, 4, 0, "shift3");
    do_op(1'b0, 8'd130, 25'h0180000, 32'h3FC00000, 3'b000, 4, 0, "shift3_man");
    do_op(1'b0, 8'd100, 25'h0000000, 32'h00000000, 3'b001, 1, 0, "zero");
    do_op(1'b1, 8'd254, 25'h1000000, 32'hFF800000, 3'b100, 1, 0, "carry_ovf");
    do_op(1'b0, 8'd253, 25'h1000000, 32'h7F000000, 3'b000, 1, 0, "carry_max");
    do_op(1'b0, 8'd255, 25'h0800000, 32'h7F800000, 3'b100, 1, 0, "exp255");
    do_op(1'b0, 8'd2,   25'h0000001, 32'h00000000, 3'b010, 3, 0, "shift_unf");
    do_op(1'b0, 8'd0,   25'h0800000, 32'h00000000, 3'b010, 1, 0, "denorm");
    do_op(1'b0, 8'd100, 25'h0000001, 32'h26800000, 3'b000, 24, 0, "shift23");
    do_op(1'b0, 8'd127, 25'h0C00000, 32'h3FC00000, 3'b000, 1, 5, "backpressure");
    do_op(1'b1, 8'd130, 25'h0100000, 32'hBF800000, 3'b000, 4, 0, "shift3_neg");

    // Reset mid-SHIFT: operand is discarded, outputs clear at once.
    in_sign = 1'b0; in_exponent = 8'd130; in_fract = 25'h0100000; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    check({31'd0, out_valid}, 32'd0, "midreset.valid");
    check(out_fp, 32'd0, "midreset.fp");
    check({31'd0, in_ready}, 32'd1, "midreset.ready");
    $display("op midreset sign=0 exp=130 fract=0100000 -> discarded");
    @(posedge clock); #3;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check({31'd0, out_valid}, 32'd0, "midreset.no_output");
    do_op(1'b0, 8'd127, 25'h0C00000, 32'h3FC00000, 3'b000, 1, 0, "after_reset");
    check(exp_q.size(), 32'd0, "queue_drained");

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
